mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - Sequences every MEM-stage data access of the LC-3b datapath onto the dcache port.
// - Covers LDW/LDR, LDB, STW/STR, STB, LDI, STI and TRAP vector fetch.
// - Generates read/write strobes, byte enables and write-lane replication, and runs the
//   two-access indirect sequences.
// - Performs byte-lane extraction with sign extension, and flags dcache accesses that never respond.
// PARAMETERS
// - WAIT_LIMIT  255  max cycles one dcache access may wait for dcache_resp; 0 disables watchdog
// PORTS
// - clk                     in   1   clock; all state updates on rising edge
// - rst                     in   1   synchronous, active-high reset
// - req_valid               in   1   datapath requests an access (sampled only when req_ready=1)
// - req_op                  in   3   000 LDW, 001 LDB, 010 STW, 011 STB, 100 LDI, 101 STI, 110 TRAP; 111 reserved
// - req_addr                in   16  effective address (TRAP: vector table address)
// - req_wdata               in   16  store data
// - req_ready               out  1   1 in IDLE only
// - done                    out  1   one-cycle pulse: operation complete, rdata valid same cycle
// - rdata                   out  16  load result; held until next done
// - err                     out  1   one-cycle pulse with done if watchdog expired or op=111
// - dcache_read             out  1   read strobe, held until dcache_resp
// - dcache_write            out  1   write strobe, held until dcache_resp
// - dcache_address          out  16  access address
// - dcache_wdata            out  16  write data
// - dcache_mem_byte_enable  out  2   [1]=high byte, [0]=low byte
// - dcache_resp             in   1   access complete (read data valid this cycle)
// - dcache_rdata            in   16  read data
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1, done=0, err=0, rdata=0, strobes=0, byte_enable=2'b11, wait counter=0.
// - Reset mid-operation: abandon access; strobes low on cycle after reset edge, no done.
// - States: IDLE, PTR (indirect pointer read), ACC (final access), FIN (done pulse).
//   - IDLE & req_valid:
//     - latch op/addr/wdata;
//     - LDI/STI -> PTR; op 111 -> FIN with err=1; else -> ACC.
//   - PTR:
//     - dcache_read=1, address={addr[15:1],1'b0}, byte_enable=11;
//     - on resp, latch pointer=dcache_rdata -> ACC.
//   - ACC: final access on latched address (pointer for LDI/STI); on resp -> FIN.
//   - FIN: done=1 for one cycle -> IDLE. Next req accepted in IDLE, no back-to-back accept in FIN.
// - Address and enables:
//   - Word ops (LDW, STW, LDI, STI, TRAP, PTR): address bit0 forced to 0, byte_enable=11.
//   - Byte ops: address unmodified; byte_enable=2'b10 if addr[0] else 2'b01.
// - Write data:
//   - STW/STI: dcache_wdata=req_wdata.
//   - STB: dcache_wdata={wdata[7:0],wdata[7:0]}.
//   - dcache_write only in ACC for store ops.
// - Read data (latched into rdata on ACC resp):
//   - LDW/LDI/TRAP: rdata=dcache_rdata.
//   - LDB: selected byte (high if addr[0]) sign-extended to 16 bits.
//   - Stores leave rdata unchanged.
// - Minimum latency, resp in first strobe cycle:
//   - direct op: accept(IDLE)->ACC->FIN = done 2 cycles after accept;
//   - indirect op: done 3 cycles after accept.
// - Watchdog:
//   - counter clears on entering PTR/ACC and increments each strobe cycle without resp.
//   - At count==WAIT_LIMIT (nonzero) -> FIN with done=1, err=1, strobes dropped, rdata unchanged.
// - Simultaneous resp and watchdog expiry: resp wins, err=0.
// - Strobes never both high; req inputs ignored outside IDLE.
// TESTING
// - LDB: addr=0x3001, rdata_in=0x80FF, resp on first cycle -> be=10, rdata=0xFF80, done 2 cycles after accept.
// - STB: addr=0x2000, wdata=0x12AB -> dcache_wdata=0xABAB, be=01, write held through 3 stall cycles until resp.
// - LDI: addr=0x4001, ptr read returns 0x5003, final read 0x1234 -> addresses 0x4000 then 0x5002, rdata=0x1234.
// - STI: ptr=0x6000, wdata=0xBEEF -> read 0x…, write 0xBEEF to 0x6000 with be=11, done; rdata unchanged.
// - Watchdog: WAIT_LIMIT=4, LDW never resp -> done+err after 4 wait cycles, strobe low; resp on limit cycle -> err=0.
// - rst asserted in PTR of LDI -> next cycle IDLE, strobes 0, no done; following LDW 0x0010 completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - LC-3b MEM-stage dcache access sequencer
// Direct, byte and indirect (pointer-then-access) loads/stores with a dcache response watchdog.
module mem_access_ctrl #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        dcache_read,
    output logic        dcache_write,
    output logic [15:0] dcache_address,
    output logic [15:0] dcache_wdata,
    output logic [1:0]  dcache_mem_byte_enable,
    input  logic        dcache_resp,
    input  logic [15:0] dcache_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PTR  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [2:0] OP_LDB = 3'b001;
    localparam logic [2:0] OP_STW = 3'b010;
    localparam logic [2:0] OP_STB = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;
    localparam logic [2:0] OP_STI = 3'b101;
    localparam logic [2:0] OP_RSV = 3'b111;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  wait_q, wait_d;

    logic        is_store, is_byte, is_ind, expire;
    logic [15:0] acc_addr;
    logic [7:0]  sel_byte;

    assign is_store = (op_q == OP_STW) || (op_q == OP_STB) || (op_q == OP_STI);
    assign is_byte  = (op_q == OP_LDB) || (op_q == OP_STB);
    assign is_ind   = (op_q == OP_LDI) || (op_q == OP_STI);
    assign acc_addr = is_ind ? ptr_q : addr_q;
    assign sel_byte = addr_q[0] ? dcache_rdata[15:8] : dcache_rdata[7:0];
    // A response arriving on the limit cycle still completes the access normally.
    assign expire   = (LIMIT != 8'd0) && (wait_q == LIMIT) && !dcache_resp;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wait_d  = 8'd0;
                    if (req_op == OP_RSV) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else if ((req_op == OP_LDI) || (req_op == OP_STI)) begin
                        state_d = S_PTR;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_PTR: begin
                if (dcache_resp) begin
                    ptr_d   = dcache_rdata;
                    wait_d  = 8'd0;
                    state_d = S_ACC;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_ACC: begin
                if (dcache_resp) begin
                    state_d = S_FIN;
                    if (!is_store) begin
                        rdata_d = is_byte ? {{8{sel_byte[7]}}, sel_byte} : dcache_rdata;
                    end
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign done           = (state_q == S_FIN);
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign dcache_read    = (state_q == S_PTR) || ((state_q == S_ACC) && !is_store);
    assign dcache_write   = (state_q == S_ACC) && is_store;
    assign dcache_address = (state_q == S_PTR) ? {addr_q[15:1], 1'b0}
                          : (is_byte ? acc_addr : {acc_addr[15:1], 1'b0});
    assign dcache_mem_byte_enable = ((state_q == S_ACC) && is_byte)
                                  ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
    assign dcache_wdata   = (op_q == OP_STB) ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a stalling dcache model
module tb_mem_access_ctrl;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, done, err;
    logic [15:0] rdata;
    logic        dcache_read, dcache_write, dcache_resp;
    logic [15:0] dcache_address, dcache_wdata, dcache_rdata;
    logic [1:0]  dcache_mem_byte_enable;

    mem_access_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .done(done), .rdata(rdata), .err(err),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_mem_byte_enable(dcache_mem_byte_enable),
        .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  be;
        logic        wr;
        logic [15:0] wdata;
    } acc_t;

    exp_t        exp_q[$];
    acc_t        acc_q[$];
    int          stall_q[$];
    logic [15:0] dc_mem    [0:32767];
    logic [15:0] model_mem [0:32767];
    logic [15:0] model_rdata;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Responder: each strobe episode is one access; it answers after the stall the stimulus queued.
    initial begin : responder
        bit          active;
        int          cnt, cur_stall;
        logic [15:0] w;
        acc_t        ea;
        active = 0; cnt = 0; cur_stall = 0;
        dcache_resp = 1'b0;
        dcache_rdata = '0;
        forever begin
            @(negedge clk);
            dcache_resp = 1'b0;
            if (rst || !(dcache_read || dcache_write)) begin
                active = 0;
            end else begin
                check("strobe_excl", {31'b0, dcache_read & dcache_write}, 32'd0);
                if (!active) begin
                    active = 1;
                    cnt = 0;
                    cur_stall = (stall_q.size() != 0) ? stall_q.pop_front() : 0;
                    if (acc_q.size() == 0) begin
                        check("unexpected_access", {16'b0, dcache_address}, 32'hFFFF_FFFF);
                    end else begin
                        ea = acc_q.pop_front();
                        check("acc_addr", {16'b0, dcache_address}, {16'b0, ea.addr});
                        check("acc_be", {30'b0, dcache_mem_byte_enable}, {30'b0, ea.be});
                        check("acc_write", {31'b0, dcache_write}, {31'b0, ea.wr});
                        if (ea.wr) check("acc_wdata", {16'b0, dcache_wdata}, {16'b0, ea.wdata});
                    end
                end
                if (cnt == cur_stall) begin
                    dcache_resp = 1'b1;
                    w = dc_mem[dcache_address[15:1]];
                    dcache_rdata = w;
                    if (dcache_write) begin
                        if (dcache_mem_byte_enable[1]) w[15:8] = dcache_wdata[15:8];
                        if (dcache_mem_byte_enable[0]) w[7:0] = dcache_wdata[7:0];
                        dc_mem[dcache_address[15:1]] = w;
                    end
                    active = 0;
                end else begin
                    cnt++;
                    dcache_rdata = 16'($urandom);
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (err && !done) check("err_without_done", 32'd1, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", {16'b0, rdata}, {16'b0, e.rdata});
                    check("err", {31'b0, err}, {31'b0, e.err});
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic preset(input logic [15:0] a, input logic [15:0] v);
        dc_mem[a[15:1]] = v;
        model_mem[a[15:1]] = v;
    endtask

    // Transaction-level reference: access list, final rdata, error and completion cycle.
    task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd,
                         input int s0, input int s1);
        int          t, sum;
        logic        e, ok, byte_op, store;
        logic [15:0] eff, a, w, wv;
        logic [7:0]  b;
        logic [1:0]  be;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
        sum = 0; e = 0; ok = 1; eff = addr;
        if (op == 3'd7) begin
            e = 1;
        end else begin
            if (op == 3'd4 || op == 3'd5) begin
                acc_q.push_back('{{addr[15:1], 1'b0}, 2'b11, 1'b0, 16'h0});
                stall_q.push_back(s0);
                if (s0 > LIMIT) begin
                    sum += LIMIT + 1; e = 1; ok = 0;
                end else begin
                    sum += s0 + 1;
                    eff = model_mem[addr[15:1]];
                end
            end
            if (ok) begin
                byte_op = (op == 3'd1) || (op == 3'd3);
                store   = (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
                a  = byte_op ? eff : {eff[15:1], 1'b0};
                be = byte_op ? (eff[0] ? 2'b10 : 2'b01) : 2'b11;
                wv = (op == 3'd3) ? {wd[7:0], wd[7:0]} : wd;
                acc_q.push_back('{a, be, store, wv});
                stall_q.push_back(s1);
                if (s1 > LIMIT) begin
                    sum += LIMIT + 1; e = 1;
                end else begin
                    sum += s1 + 1;
                    w = model_mem[a[15:1]];
                    if (store) begin
                        if (!byte_op) w = wd;
                        else if (a[0]) w[15:8] = wd[7:0];
                        else w[7:0] = wd[7:0];
                        model_mem[a[15:1]] = w;
                    end else if (op == 3'd1) begin
                        b = a[0] ? w[15:8] : w[7:0];
                        model_rdata = {{8{b[7]}}, b};
                    end else begin
                        model_rdata = w;
                    end
                end
            end
        end
        exp_q.push_back('{model_rdata, e, cyc + 1 + sum});
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 3'($urandom);
        req_addr = 16'($urandom);
        req_wdata = 16'($urandom);
    endtask

    function automatic int rnd_stall();
        return ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 7));
    endfunction

    initial begin : stimulus
        int t;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        model_rdata = '0;
        for (int i = 0; i < 32768; i++) begin
            dc_mem[i] = 16'($urandom);
            model_mem[i] = dc_mem[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_rdata", {16'b0, rdata}, 32'd0);
        check("rst_strobes", {30'b0, dcache_read, dcache_write}, 32'd0);
        check("rst_be", {30'b0, dcache_mem_byte_enable}, 32'd3);
        rst = 1'b0;

        preset(16'h3000, 16'h80FF);
        issue(3'd1, 16'h3001, 16'h0000, 0, 0);
        issue(3'd3, 16'h2000, 16'h12AB, 0, 3);
        preset(16'h4000, 16'h5003);
        preset(16'h5002, 16'h1234);
        issue(3'd4, 16'h4001, 16'h0000, 0, 0);
        preset(16'h7000, 16'h6000);
        issue(3'd5, 16'h7000, 16'hBEEF, 1, 0);
        issue(3'd0, 16'h6000, 16'h0000, 0, 0);
        issue(3'd0, 16'h0100, 16'h0000, 0, 10);
        issue(3'd0, 16'h0102, 16'h0000, 0, LIMIT);
        issue(3'd4, 16'h0200, 16'h0000, 7, 0);
        issue(3'd7, 16'h0300, 16'h5555, 0, 0);
        issue(3'd6, 16'h0020, 16'h0000, 2, 0);

        // Reset while the LDI pointer read is stalled.
        issue(3'd4, 16'h4001, 16'h0000, 3, 0);
        check("ptr_read_active", {31'b0, dcache_read}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_strobes", {30'b0, dcache_read, dcache_write}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_rdata", {16'b0, rdata}, 32'd0);
        exp_q.delete();
        acc_q.delete();
        stall_q.delete();
        model_rdata = '0;
        rst = 1'b0;
        issue(3'd0, 16'h0010, 16'h0000, 0, 0);

        for (int i = 0; i < 300; i++) begin
            issue(($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
                  16'($urandom), 16'($urandom), rnd_stall(), rnd_stall());
        end

        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
